// File: rtl/oc8051_pt_pkg.sv
// Shared constants, state encoding and bus payload for the page-table loader.
package oc8051_pt_pkg;

  localparam logic [15:0] PT_WR_BASE = 16'hFF80;
  localparam logic [15:0] PT_RD_BASE = 16'hFFA0;
  localparam logic [15:0] IA_BASE    = 16'hFFC0;
  localparam int unsigned PT_BYTES   = 64;

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRC_RD,
    ST_PT_WR,
    ST_PT_VFY,
    ST_DONE,
    ST_ERR
  } state_t;

  // One page-table bus request.
  typedef struct packed {
    logic        stb;
    logic        wr;
    logic        priv;
    logic [15:0] addr;
    logic [7:0]  data;
  } pt_bus_t;

endpackage

// File: rtl/oc8051_pt_bus_mux.sv
// Page-table bus arbiter: loader owns the bus while loading, CPU otherwise.
module oc8051_pt_bus_mux
  import oc8051_pt_pkg::*;
(
  input  logic    i_own,
  input  pt_bus_t i_ldr,
  input  pt_bus_t i_cpu,
  input  logic    i_pt_ack,
  output pt_bus_t o_pt_c,
  output logic    o_cpu_ack_c,
  output logic    o_cpu_stall_c
);

  // Select bus master and generate CPU handshake.
  always_comb begin
    o_pt_c        = i_ldr;
    o_cpu_ack_c   = 1'b0;
    o_cpu_stall_c = 1'b0;
    if (i_own) begin
      o_cpu_stall_c = i_cpu.stb;
    end else begin
      o_pt_c      = i_cpu;
      o_cpu_ack_c = i_pt_ack;
    end
  end

endmodule

// File: rtl/oc8051_pt_loader.sv
// Page-table permission loader: copies NUM_BYTES from the boot source into
// the page-table registers. Define PT_LOADER_VERIFY_EN to read back and
// compare every byte after it is written.
module oc8051_pt_loader
  import oc8051_pt_pkg::*;
#(
  parameter logic [15:0] SRC_BASE    = 16'h0000,
  parameter logic [15:0] PT_BASE     = PT_WR_BASE,
  parameter int unsigned NUM_BYTES   = PT_BYTES,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_auto_start,
  output logic              o_src_stb,
  output logic [15:0]       o_src_addr,
  input  logic              i_src_ack,
  input  logic [7:0]        i_src_data,
  output logic              o_pt_stb,
  output logic              o_pt_wr,
  output logic [15:0]       o_pt_addr,
  output logic [7:0]        o_pt_data,
  output logic              o_pt_priv,
  input  logic              i_pt_ack,
  input  logic [7:0]        i_pt_rdata,
  input  logic              i_cpu_stb,
  input  logic              i_cpu_wr,
  input  logic              i_cpu_priv,
  input  logic [15:0]       i_cpu_addr,
  input  logic [7:0]        i_cpu_data,
  output logic              o_cpu_ack,
  output logic              o_cpu_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_count
);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [7:0]          r_byte, w_byte_nxt;
  logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic                r_auto;
  logic                r_busy;
  logic                r_src_stb;
  logic [15:0]         r_src_addr;
  pt_bus_t             r_ldr;
  logic                w_go, w_adv, w_tmo;
  logic                w_in_wr, w_in_vfy;
  pt_bus_t             w_cpu, w_pt;

`ifndef PT_LOADER_VERIFY_EN
  logic [7:0] w_unused_rdata;
  assign w_unused_rdata = i_pt_rdata;
`endif

  // Next-state, index, counter and status computation.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_count;
    w_byte_nxt  = r_byte;
    w_wait_nxt  = r_wait;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_go        = 1'b0;
    w_adv       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        w_go = i_start || ((r_state == ST_IDLE) && r_auto);
      end
      ST_SRC_RD: begin
        if (i_src_ack) begin
          w_byte_nxt  = i_src_data;
          w_state_nxt = ST_PT_WR;
          w_wait_nxt  = '0;
        end else begin
          w_tmo = 1'b1;
        end
      end
      ST_PT_WR: begin
        if (i_pt_ack) begin
`ifdef PT_LOADER_VERIFY_EN
          w_state_nxt = ST_PT_VFY;
          w_wait_nxt  = '0;
`else
          w_adv = 1'b1;
`endif
        end else begin
          w_tmo = 1'b1;
        end
      end
`ifdef PT_LOADER_VERIFY_EN
      ST_PT_VFY: begin
        if (i_pt_ack) begin
          if (i_pt_rdata == r_byte) begin
            w_adv = 1'b1;
          end else begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_tmo = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    // A new load clears all status from the previous one.
    if (w_go) begin
      w_state_nxt = ST_SRC_RD;
      w_idx_nxt   = '0;
      w_count_nxt = '0;
      w_wait_nxt  = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end

    // Byte committed: step to the next source byte or finish.
    if (w_adv) begin
      w_idx_nxt   = r_idx + IDX_W'(1);
      w_count_nxt = r_count + CNT_W'(1);
      w_wait_nxt  = '0;
      if (r_idx == IDX_W'(NUM_BYTES - 1)) begin
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_SRC_RD;
      end
    end

    // Missing ack: count, then abort; already-written bytes stay in place.
    if (w_tmo) begin
      if (r_wait == WAIT_W'(ACK_TIMEOUT - 1)) begin
        w_state_nxt = ST_ERR;
        w_err_nxt   = 1'b1;
      end else begin
        w_wait_nxt = r_wait + WAIT_W'(1);
      end
    end
  end

  assign w_in_wr  = (w_state_nxt == ST_PT_WR);
  assign w_in_vfy = (w_state_nxt == ST_PT_VFY);

  // State register and registered bus/status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_count    <= '0;
      r_byte     <= '0;
      r_wait     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_auto     <= i_auto_start;
      r_busy     <= 1'b0;
      r_src_stb  <= 1'b0;
      r_src_addr <= '0;
      r_ldr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_count    <= w_count_nxt;
      r_byte     <= w_byte_nxt;
      r_wait     <= w_wait_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      if (w_go) r_auto <= 1'b0;
      r_busy     <= (w_state_nxt == ST_SRC_RD) || w_in_wr || w_in_vfy;
      r_src_stb  <= (w_state_nxt == ST_SRC_RD);
      r_src_addr <= (w_state_nxt == ST_SRC_RD) ? (SRC_BASE + 16'(w_idx_nxt)) : '0;
      r_ldr.stb  <= w_in_wr || w_in_vfy;
      r_ldr.wr   <= w_in_wr;
      r_ldr.priv <= w_in_wr || w_in_vfy;
      r_ldr.addr <= (w_in_wr || w_in_vfy) ? (PT_BASE + 16'(w_idx_nxt)) : '0;
      r_ldr.data <= w_in_wr ? w_byte_nxt : '0;
    end
  end

  assign w_cpu = '{stb: i_cpu_stb, wr: i_cpu_wr, priv: i_cpu_priv,
                   addr: i_cpu_addr, data: i_cpu_data};

  // The loader also claims the bus in the cycle a start is accepted.
  oc8051_pt_bus_mux u_mux (
    .i_own         (r_busy || w_go),
    .i_ldr         (r_ldr),
    .i_cpu         (w_cpu),
    .i_pt_ack      (i_pt_ack),
    .o_pt_c        (w_pt),
    .o_cpu_ack_c   (o_cpu_ack),
    .o_cpu_stall_c (o_cpu_stall)
  );

  assign o_pt_stb   = w_pt.stb;
  assign o_pt_wr    = w_pt.wr;
  assign o_pt_priv  = w_pt.priv;
  assign o_pt_addr  = w_pt.addr;
  assign o_pt_data  = w_pt.data;
  assign o_src_stb  = r_src_stb;
  assign o_src_addr = r_src_addr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_count    = r_count;

endmodule

// File: tb/tb_oc8051_pt_loader.sv
// Scoreboard bench for oc8051_pt_loader: stimulus pushes expected page-table
// writes, a monitor pops them whenever a write is acknowledged on the bus.
module tb_oc8051_pt_loader;

`ifdef PT_LOADER_VERIFY_EN
  localparam int CPB = 3;
`else
  localparam int CPB = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        auto_start = 1'b1;
  logic        src_stb;
  logic [15:0] src_addr;
  logic        src_ack;
  logic [7:0]  src_data;
  logic        pt_stb, pt_wr, pt_priv;
  logic [15:0] pt_addr;
  logic [7:0]  pt_data;
  logic        pt_ack;
  logic [7:0]  pt_rdata;
  logic        cpu_stb = 1'b0, cpu_wr = 1'b0, cpu_priv = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_data = 8'h0;
  logic        cpu_ack, cpu_stall, busy, done, err;
  logic [6:0]  count;

  int          total = 0;
  int          bad = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  int          src_dly = 0;
  int          src_wc = 0;
  logic        pt_block = 1'b0;
  logic        corrupt = 1'b0;
  logic [7:0]  pt_mem[64];
  logic        act = 1'b0, ovl = 1'b0, gap = 1'b0;
  int          n, t0;

  oc8051_pt_loader dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_auto_start(auto_start),
    .o_src_stb(src_stb), .o_src_addr(src_addr), .i_src_ack(src_ack), .i_src_data(src_data),
    .o_pt_stb(pt_stb), .o_pt_wr(pt_wr), .o_pt_addr(pt_addr), .o_pt_data(pt_data),
    .o_pt_priv(pt_priv), .i_pt_ack(pt_ack), .i_pt_rdata(pt_rdata),
    .i_cpu_stb(cpu_stb), .i_cpu_wr(cpu_wr), .i_cpu_priv(cpu_priv),
    .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
    .o_cpu_ack(cpu_ack), .o_cpu_stall(cpu_stall),
    .o_busy(busy), .o_done(done), .o_err(err), .o_count(count)
  );

  always #5 clk = ~clk;

  // Boot source: byte at offset i is i ^ A5, acked after src_dly wait cycles.
  assign src_data = src_addr[7:0] ^ 8'hA5;
  assign src_ack  = src_stb && (src_wc >= src_dly);
  always @(posedge clk) src_wc <= (src_stb && !src_ack) ? src_wc + 1 : 0;

  // Page-table model: zero-wait ack, optional stuck write at FF8A, optional bad readback at FF85.
  assign pt_ack   = pt_stb && !(pt_block && pt_wr && pt_addr == 16'hFF8A);
  assign pt_rdata = pt_mem[pt_addr[5:0]] ^ ((corrupt && pt_addr == 16'hFF85) ? 8'h5A : 8'h00);
  always @(posedge clk)
    if (pt_stb && pt_wr && pt_ack && pt_addr[15:6] == 10'h3FE) pt_mem[pt_addr[5:0]] <= pt_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_load(input int nbytes);
    for (int i = 0; i < nbytes; i++)
      exp_q.push_back({16'hFF80 + 16'(i), 8'(i) ^ 8'hA5});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for the load to end; records any busy gap on the way.
  task automatic wait_end(input int budget, output int cycles);
    cycles = 0;
    while (!(done || err) && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (!busy && !done && !err) gap = 1'b1;
    end
    check("load_end", 32'(done || err), 32'd1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (src_stb || pt_stb) act = 1'b1;
        if (src_stb && pt_stb) ovl = 1'b1;
        if (pt_stb && pt_wr && pt_ack) begin
          check("sb_expect", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("sb_addr", 32'(pt_addr), 32'(mon_e[23:8]));
            check("sb_data", 32'(pt_data), 32'(mon_e[7:0]));
            if (busy) check("sb_priv", 32'(pt_priv), 32'd1);
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_count", 32'(count), 0);
    check("rst_src_stb", 32'(src_stb), 0);
    check("rst_pt_stb", 32'(pt_stb), 0);

    // Auto-start load with zero-wait acks.
    push_load(64);
    rst = 1'b1;
    wait_end(400, n);
    check("auto_latency", 32'(n), 32'(64 * CPB + 1));
    check("auto_done", 32'(done), 1);
    check("auto_count", 32'(count), 64);
    check("auto_busy", 32'(busy), 0);
    check("auto_q_empty", 32'(exp_q.size()), 0);

    // Start pulse, source acks delayed 3 cycles; a second start mid-load is ignored.
    src_dly = 3;
    gap = 1'b0;
    ovl = 1'b0;
    push_load(64);
    pulse_start();
    check("t2_done_clr", 32'(done), 0);
    check("t2_busy", 32'(busy), 1);
    repeat (40) @(negedge clk);
    pulse_start();
    check("t2_busy_hold", 32'(busy), 1);
    wait_end(800, n);
    check("t2_done", 32'(done), 1);
    check("t2_count", 32'(count), 64);
    check("t2_no_gap", 32'(gap), 0);
    check("t2_no_overlap", 32'(ovl), 0);
    check("t2_q_empty", 32'(exp_q.size()), 0);

    // pt_ack withheld at byte 10 -> timeout abort, then a clean reload.
    src_dly = 0;
    pt_block = 1'b1;
    push_load(10);
    pulse_start();
    n = 0;
    t0 = -1;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
      if (t0 < 0 && pt_stb && pt_wr && pt_addr == 16'hFF8A) t0 = n;
    end
    check("tmo_latency", 32'(n - t0), 32'd15);
    check("tmo_err", 32'(err), 1);
    check("tmo_done", 32'(done), 0);
    check("tmo_count", 32'(count), 10);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_q_empty", 32'(exp_q.size()), 0);
    pt_block = 1'b0;
    push_load(64);
    pulse_start();
    check("reload_err_clr", 32'(err), 0);
    wait_end(400, n);
    check("reload_done", 32'(done), 1);
    check("reload_count", 32'(count), 64);

    // Start coincides with a CPU write: loader wins and the CPU is stalled.
    push_load(64);
    @(posedge clk);
    #1;
    start = 1'b1;
    cpu_stb = 1'b1; cpu_wr = 1'b1; cpu_priv = 1'b0;
    cpu_addr = 16'hFF85; cpu_data = 8'h3C;
    @(negedge clk);
    check("arb_stall0", 32'(cpu_stall), 1);
    check("arb_ack0", 32'(cpu_ack), 0);
    check("arb_pt_stb0", 32'(pt_stb), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("arb_stall", 32'(cpu_stall), 1);
      check("arb_ack", 32'(cpu_ack), 0);
    end
    @(posedge clk);
    #1;
    cpu_stb = 1'b0;
    wait_end(400, n);
    check("arb_done", 32'(done), 1);
    // Idle: CPU write to FF85 passes straight through.
    @(posedge clk);
    #1;
    exp_q.push_back({16'hFF85, 8'h3C});
    cpu_stb = 1'b1;
    @(negedge clk);
    check("pass_ack", 32'(cpu_ack), 1);
    check("pass_stall", 32'(cpu_stall), 0);
    check("pass_data", 32'(pt_data), 32'h3C);
    @(posedge clk);
    #1;
    cpu_stb = 1'b0;
    @(negedge clk);
    check("pass_q_empty", 32'(exp_q.size()), 0);

    // Reset during byte 30 with auto_start low: back to idle, bus quiet.
    push_load(30);
    pulse_start();
    n = 0;
    while (count != 7'd30 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach30", 32'(count), 30);
    rst = 1'b0;
    auto_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    act = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_err", 32'(err), 0);
    check("mid_count", 32'(count), 0);
    check("mid_quiet", 32'(act), 0);
    check("mid_q_empty", 32'(exp_q.size()), 0);

`ifdef PT_LOADER_VERIFY_EN
    // Readback corrupted at byte 5: abort with count left at 5.
    corrupt = 1'b1;
    push_load(6);
    pulse_start();
    wait_end(400, n);
    check("vfy_err", 32'(err), 1);
    check("vfy_count", 32'(count), 5);
    check("vfy_q_empty", 32'(exp_q.size()), 0);
    corrupt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oc8051_pt_loader.md
Name: oc8051_pt_loader

Overview:
- Sequencer that loads page-table permission bytes into the page-table register block after reset or on a privileged request.
- Reads 64 bytes from a boot-image source port: 32 write-enable bytes, then 32 read-enable bytes.
- Writes them over the XRAM-style page-table bus at 0xFF80–0xFFBF.
- Owns that bus while loading and stalls the CPU's page-table accesses; passes CPU accesses through when idle.

Parameters:
- SRC_BASE, 16'h0000, source address of the first permission byte.
- PT_BASE, 16'hFF80, page-table address of the first write-enable byte.
- NUM_BYTES, 64, bytes per load; must be even and ≤64.
- ACK_TIMEOUT, 15, cycles to wait for any ack before aborting; 4-bit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle load request; honoured only in IDLE or DONE/ERR.
- auto_start  in  1  sampled at reset release; 1 = begin a load on the first cycle out of reset.
- src_stb  out  1  source read strobe.
- src_addr  out  16  source read address.
- src_ack  in  1  source data valid.
- src_data  in  8  source read data.
- pt_stb  out  1  page-table bus strobe.
- pt_wr  out  1  page-table write.
- pt_addr  out  16  page-table address.
- pt_data  out  8  page-table write data.
- pt_priv  out  1  privilege level presented to the page table.
- pt_ack  in  1  page-table ack.
- pt_rdata  in  8  page-table read data.
- cpu_stb, cpu_wr, cpu_priv  in  1 each  CPU page-table request.
- cpu_addr  in  16  CPU address.
- cpu_data  in  8  CPU write data.
- cpu_ack  out  1  ack returned to the CPU.
- cpu_stall  out  1  CPU request blocked while loading.
- busy  out  1  load in progress.
- done  out  1  sticky; last load completed.
- err  out  1  sticky; last load aborted.
- count  out  7  bytes written in the current or last load.

Behaviour:
- Reset (rst low): state IDLE; all outputs 0; count 0; byte index 0.
- States and transitions:
  - IDLE →(start or auto_start-at-release) SRC_RD.
  - SRC_RD: src_stb=1, src_addr=SRC_BASE+idx.
    - On src_ack: latch src_data, drop src_stb the same cycle, go PT_WR.
  - PT_WR: pt_stb=1, pt_wr=1, pt_priv=1, pt_addr=PT_BASE+idx, pt_data=latched byte.
    - On pt_ack: idx+1, count+1.
    - If idx == NUM_BYTES-1, go DONE; else go SRC_RD.
  - DONE: done=1, busy=0; start → SRC_RD.
  - ERR: err=1, busy=0; start → SRC_RD.
- Load timing:
  - Minimum 2 cycles per byte with zero-wait acks, so a 64-byte load takes 128 cycles.
  - busy is high from the cycle after start until the DONE/ERR entry cycle.
- Starting a load clears done, err, idx and count.
- Timeout:
  - Wait counter resets on each state entry and increments while awaiting an ack.
  - Reaching ACK_TIMEOUT → ERR. Pages written so far stay written.
- Arbitration:
  - While busy, cpu_stall = cpu_stb, cpu_ack = 0, and CPU signals never reach the pt_* outputs.
  - While not busy, pt_* mirror the CPU signals combinationally and cpu_ack = pt_ack.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as a CPU request: the loader wins; the CPU request is stalled.
- Address arithmetic is 16-bit modulo; idx is 6 bits. NUM_BYTES=64 ends exactly at PT_BASE+63.
- Reset mid-load: immediate return to IDLE; partial page-table contents are retained. auto_start is re-sampled at release.

Optional Feature:
- PT_LOADER_VERIFY_EN defined: after each pt_ack on a write, add state PT_VFY.
  - PT_VFY: pt_stb=1, pt_wr=0, same address, pt_priv=1.
  - On pt_ack, compare pt_rdata with the latched byte. Mismatch → ERR with count unchanged; match → advance as normal.
  - Minimum cost becomes 3 cycles per byte.
- Undefined: PT_VFY is absent and pt_rdata is unused.

Decomposition:
- Shared package oc8051_pt_pkg holds:
  - Address constants: PT_WR_BASE 16'hFF80, PT_RD_BASE 16'hFFA0, IA_BASE 16'hFFC0.
  - State encoding: IDLE, SRC_RD, PT_WR, PT_VFY, DONE, ERR.
  - PT_BYTES = 64.
- One sub-module, oc8051_pt_bus_mux: the combinational mux between loader and CPU driving the pt_* outputs, plus cpu_ack/cpu_stall generation.

Test Plan:
- auto_start=1 at reset release, zero-wait acks, src bytes = idx^8'hA5 → 64 writes to FF80..FFBF; done=1, count=64; done rises at cycle 128 after release.
- start pulse while idle, src_ack delayed 3 cycles per byte → correct data at every pt_addr; busy stays high throughout; no write overlaps a source read.
- pt_ack withheld at byte 10 → ERR at ACK_TIMEOUT cycles after pt_stb rises; err=1, count=10; next start → clean full load.
- CPU write to FF85 during a load → cpu_stall=1, cpu_ack=0, no CPU value on pt_data; after done, CPU write to FF85 passes through and cpu_ack follows pt_ack.
- rst low at byte 30, then auto_start=0 at release → IDLE; busy, done and err all 0; no further bus activity until start.
- PT_LOADER_VERIFY_EN, page table model corrupts readback at byte 5 → ERR, count=5; with no corruption → done, 192 cycles minimum.
